network_acc_requant_30s_16s: RTL and testbench
==============================================

// Module: network_acc_requant_30s_16s
// PURPOSE
//   Consumer end of the 16s x 14s -> 30s product path of the conv/deconv layers.
//   Accumulates a stream of signed 30-bit products into a wide accumulator.
//   On the last product of a vector it rounds, shifts, optionally applies ReLU, and saturates.
//   It returns one signed 16-bit activation to the next layer over a valid/ready handshake.
// PARAMETERS
//   IN_WIDTH   30  signed product width (prod_dat)
//   ACC_WIDTH  40  signed accumulator width; must be >= IN_WIDTH + clog2(max beats per vector)
//   OUT_WIDTH  16  signed activation width (out_dat)
//   SHIFT_W    5   width of shift control (right shift 0..31)
// PORTS
//   ap_clk     in   1          clock, all logic rising-edge
//   ap_rst     in   1          synchronous reset, active-high
//   prod_dat   in   IN_WIDTH   signed product beat
//   prod_vld   in   1          prod_dat valid
//   prod_last  in   1          qualifies beat as last of vector (sampled with prod_vld&prod_rdy)
//   prod_rdy   out  1          block accepts a beat this cycle
//   shift      in   SHIFT_W    requant right-shift, sampled on accepted last beat
//   relu_en    in   1          clamp negative results to 0, sampled on accepted last beat
//   out_dat    out  OUT_WIDTH  signed activation
//   out_vld    out  1          out_dat valid
//   out_rdy    in   1          downstream accepts out_dat
//   ovf_cnt    out  16         count of saturated results, sticks at 0xFFFF
// BEHAVIOUR
//   Reset (ap_rst=1 at an edge): state=ACC, acc=0, sum_r=0, out_dat=0, out_vld=0, ovf_cnt=0.
//     Takes effect mid-vector or mid-hold; a partial vector or an unsent result is discarded.
//   prod_rdy = (state==ACC) combinationally; out_vld is a register.
//   FSM:
//     ACC   : beat accepted (prod_vld&prod_rdy), prod_last=0 -> acc <= acc + sext(prod_dat).
//             beat accepted, prod_last=1 -> sum_r <= acc + sext(prod_dat); acc <= 0.
//               Also latches shift and relu_en, then goes to ROUND.
//             No beat accepted -> hold.
//     ROUND : out_dat <= requant(sum_r); out_vld <= 1; update ovf_cnt; -> HOLD.
//     HOLD  : out_rdy=1 -> out_vld <= 0, -> ACC.
//             out_rdy=0 -> out_dat and out_vld held stable.
//   Latency and throughput:
//     Last beat accepted at cycle T -> out_vld=1 from cycle T+2.
//     An N-beat vector occupies >= N+2 cycles; no beats are accepted in ROUND or HOLD.
//   Single-beat vector (prod_last on first beat) is legal: result = requant(sext(beat)).
//   Accumulation wraps modulo 2^ACC_WIDTH (two's complement).
//     No overflow detection in acc; the parameter constraint prevents overflow.
//   requant(s), signed throughout:
//     r = (shift==0) ? s : (s + (1<<(shift-1))) >>> shift   (round half toward +inf)
//     if r > 2^(OUT_WIDTH-1)-1 -> 32767, sat event.
//     if r < -2^(OUT_WIDTH-1)  -> -32768, sat event.
//     then if relu_en and result<0 -> 0.
//     ReLU zeroing is not a sat event; a negative saturation followed by ReLU still counts.
//   ovf_cnt increments by 1 per sat event in ROUND; saturates at 0xFFFF, no wrap.
//   prod_dat, prod_last and shift are ignored when not accepted; X on unaccepted inputs is tolerated.
// TESTING
//   1 accumulate: beats 100,200,300(last), shift=0, relu_en=0 -> out_dat=600, out_vld at T+2, ovf_cnt=0.
//   2 rounding: single beat 24, shift=4 -> 2; single beat -24, shift=4 -> -1; 23 shift 4 -> 1.
//   3 saturation: beats 0x1FFFFFFF,0x1FFFFFFF(last), shift=0 -> 32767, ovf_cnt=1.
//     Beat -0x20000000 (last) -> -32768, ovf_cnt=2.
//   4 backpressure: result 5 with out_rdy=0 for 6 cycles -> out_dat=5 and out_vld=1 stable, prod_rdy=0.
//     out_rdy=1 -> out_vld=0 next edge, prod_rdy=1.
//   5 relu: beats -300,-200(last), relu_en=1 -> out_dat=0, ovf_cnt unchanged.
//     Same beats with relu_en=0 -> -500.
//   6 reset mid-op: beats 1000,2000 (no last), ap_rst 1 cycle; then beat 7(last) -> out_dat=7.
//     Reset during HOLD -> out_vld=0 next cycle.

Source files
------------

// File: rtl/network_acc_requant_30s_16s.sv
// Accumulates signed 30-bit products per vector.
// It then rounds, shifts, applies optional ReLU and saturates to one 16-bit activation.
module network_acc_requant_30s_16s #(
    parameter int unsigned IN_WIDTH  = 30,
    parameter int unsigned ACC_WIDTH = 40,
    parameter int unsigned OUT_WIDTH = 16,
    parameter int unsigned SHIFT_W   = 5
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst,
    input  logic signed [IN_WIDTH-1:0]  prod_dat,
    input  logic                        prod_vld,
    input  logic                        prod_last,
    output logic                        prod_rdy,
    input  logic [SHIFT_W-1:0]          shift,
    input  logic                        relu_en,
    output logic signed [OUT_WIDTH-1:0] out_dat,
    output logic                        out_vld,
    input  logic                        out_rdy,
    output logic [15:0]                 ovf_cnt
);

    localparam int unsigned RND_W = ACC_WIDTH + 1;
    localparam int unsigned CNT_W = 16;
    localparam logic signed [RND_W-1:0] OUT_MAX = RND_W'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [RND_W-1:0] OUT_MIN = ~OUT_MAX;

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_ROUND = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic signed [ACC_WIDTH-1:0] sum_q, sum_d;
    logic [SHIFT_W-1:0]          shift_q, shift_d;
    logic                        relu_q, relu_d;
    logic signed [OUT_WIDTH-1:0] out_dat_q, out_dat_d;
    logic                        out_vld_q, out_vld_d;
    logic [CNT_W-1:0]            ovf_q, ovf_d;

    logic                        accept;
    logic signed [ACC_WIDTH-1:0] beat_ext;
    logic signed [ACC_WIDTH-1:0] beat_sum;
    logic signed [RND_W-1:0]     rnd_add;
    logic signed [RND_W-1:0]     rnd_sum;
    logic signed [RND_W-1:0]     rnd_shr;
    logic signed [OUT_WIDTH-1:0] rq_dat;
    logic                        rq_sat;

    assign prod_rdy = (state_q == ST_ACC);
    assign accept   = prod_vld & prod_rdy;
    assign beat_ext = {{(ACC_WIDTH - IN_WIDTH){prod_dat[IN_WIDTH-1]}}, prod_dat};
    assign beat_sum = acc_q + beat_ext;

    assign out_dat  = out_dat_q;
    assign out_vld  = out_vld_q;
    assign ovf_cnt  = ovf_q;

    // Round half toward +inf; one extra bit keeps the rounding add from wrapping.
    always_comb begin
        rnd_add = '0;
        if (shift_q != '0) begin
            rnd_add = RND_W'(1) << (shift_q - SHIFT_W'(1));
        end
        rnd_sum = $signed({sum_q[ACC_WIDTH-1], sum_q}) + rnd_add;
        rnd_shr = rnd_sum >>> shift_q;
        rq_sat  = 1'b0;
        rq_dat  = rnd_shr[OUT_WIDTH-1:0];
        if (rnd_shr > OUT_MAX) begin
            rq_dat = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
            rq_sat = 1'b1;
        end else if (rnd_shr < OUT_MIN) begin
            rq_dat = {1'b1, {(OUT_WIDTH - 1){1'b0}}};
            rq_sat = 1'b1;
        end
        // ReLU after saturation: a clamped negative still counts as a sat event.
        if (relu_q && rq_dat[OUT_WIDTH-1]) begin
            rq_dat = '0;
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        sum_d     = sum_q;
        shift_d   = shift_q;
        relu_d    = relu_q;
        out_dat_d = out_dat_q;
        out_vld_d = out_vld_q;
        ovf_d     = ovf_q;
        case (state_q)
            ST_ACC: begin
                if (accept) begin
                    if (prod_last) begin
                        sum_d   = beat_sum;
                        acc_d   = '0;
                        shift_d = shift;
                        relu_d  = relu_en;
                        state_d = ST_ROUND;
                    end else begin
                        acc_d = beat_sum;
                    end
                end
            end
            ST_ROUND: begin
                out_dat_d = rq_dat;
                out_vld_d = 1'b1;
                if (rq_sat && (ovf_q != '1)) begin
                    ovf_d = ovf_q + CNT_W'(1);
                end
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_rdy) begin
                    out_vld_d = 1'b0;
                    state_d   = ST_ACC;
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q   <= ST_ACC;
            acc_q     <= '0;
            sum_q     <= '0;
            shift_q   <= '0;
            relu_q    <= 1'b0;
            out_dat_q <= '0;
            out_vld_q <= 1'b0;
            ovf_q     <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            sum_q     <= sum_d;
            shift_q   <= shift_d;
            relu_q    <= relu_d;
            out_dat_q <= out_dat_d;
            out_vld_q <= out_vld_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule

// File: tb/tb_network_acc_requant_30s_16s.sv
// Self-checking bench: directed vectors plus randomized vectors.
// Results are compared against a queue-based arithmetic model of the requantizer.
module tb_network_acc_requant_30s_16s;

    localparam int unsigned IN_W  = 30;
    localparam int unsigned OUT_W = 16;
    localparam int unsigned SH_W  = 5;

    logic                    ap_clk = 1'b0;
    logic                    ap_rst;
    logic signed [IN_W-1:0]  prod_dat;
    logic                    prod_vld;
    logic                    prod_last;
    logic                    prod_rdy;
    logic [SH_W-1:0]         shift;
    logic                    relu_en;
    logic signed [OUT_W-1:0] out_dat;
    logic                    out_vld;
    logic                    out_rdy;
    logic [15:0]             ovf_cnt;

    network_acc_requant_30s_16s dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .prod_dat  (prod_dat),
        .prod_vld  (prod_vld),
        .prod_last (prod_last),
        .prod_rdy  (prod_rdy),
        .shift     (shift),
        .relu_en   (relu_en),
        .out_dat   (out_dat),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .ovf_cnt   (ovf_cnt)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        longint dat;
        longint ovf;
    } exp_t;

    int     checks   = 0;
    int     failures = 0;
    exp_t   expq[$];
    longint exp_ovf  = 0;
    longint msum     = 0;
    longint beats[16];
    bit     mon_en   = 1'b0;
    bit     rand_rdy = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Requantization straight from the arithmetic definition.
    function automatic longint requant(input longint s, input int sh, input bit relu,
                                       output bit sat);
        longint r;
        sat = 1'b0;
        if (sh == 0) r = s;
        else         r = (s + (64'sd1 <<< (sh - 1))) >>> sh;
        if (r > 32767) begin
            r   = 32767;
            sat = 1'b1;
        end else if (r < -32768) begin
            r   = -32768;
            sat = 1'b1;
        end
        if (relu && r < 0) r = 0;
        return r;
    endfunction

    // Every cycle a result is presented it must match the oldest expectation.
    always @(negedge ap_clk) begin
        if (mon_en && !ap_rst && out_vld) begin
            check("mon_prod_rdy_in_hold", longint'(prod_rdy), 0);
            if (expq.size() == 0) begin
                check("mon_unexpected_out", longint'(out_vld), 0);
            end else begin
                check("mon_out_dat", longint'(out_dat), expq[0].dat);
                check("mon_ovf_cnt", longint'(ovf_cnt), expq[0].ovf);
                if (out_rdy) void'(expq.pop_front());
            end
        end
    end

    initial begin
        forever begin
            @(posedge ap_clk);
            #1;
            if (rand_rdy) out_rdy = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #(500000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        ap_rst = 1'b1;
        expq.delete();
        msum    = 0;
        exp_ovf = 0;
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
    endtask

    task automatic idle_garbage();
        prod_vld  = 1'b0;
        prod_dat  = IN_W'($urandom);
        prod_last = 1'($urandom);
        shift     = SH_W'($urandom);
        relu_en   = 1'($urandom);
    endtask

    // Drives n beats; returns one tick after the final accepting edge.
    task automatic send_vec(input int n, input int sh, input bit relu, input bit with_last,
                            input int max_gap);
        bit     sat;
        longint r;
        int     k;
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < $urandom_range(0, max_gap); g++) begin
                idle_garbage();
                @(posedge ap_clk);
                #1;
            end
            prod_vld  = 1'b1;
            prod_dat  = IN_W'(beats[i]);
            prod_last = with_last && (i == n - 1);
            shift     = SH_W'(sh);
            relu_en   = relu;
            k = 0;
            @(negedge ap_clk);
            while (!prod_rdy && k < 60) begin
                @(negedge ap_clk);
                k++;
            end
            if (!prod_rdy) check("prod_rdy_timeout", longint'(prod_rdy), 1);
            @(posedge ap_clk);
            #1;
            msum += beats[i];
            if (prod_last) begin
                r = requant(msum, sh, relu, sat);
                if (sat && exp_ovf < 65535) exp_ovf++;
                expq.push_back('{dat: r, ovf: exp_ovf});
                msum = 0;
            end
        end
        idle_garbage();
    endtask

    // Directed result check with out_rdy=1: gap cycle, result at T+2, then drain.
    task automatic expect_result(input string name, input longint dat, input longint ovf);
        check({name, "_vld_T1"}, longint'(out_vld), 0);
        @(posedge ap_clk);
        #1;
        check({name, "_vld_T2"}, longint'(out_vld), 1);
        check({name, "_dat"}, longint'(out_dat), dat);
        check({name, "_ovf"}, longint'(ovf_cnt), ovf);
        @(posedge ap_clk);
        #1;
        check({name, "_drained"}, longint'(out_vld), 0);
    endtask

    task automatic single(input longint b, input int sh, input bit relu,
                          input string name, input longint dat, input longint ovf);
        beats[0] = b;
        send_vec(1, sh, relu, 1'b1, 0);
        expect_result(name, dat, ovf);
    endtask

    initial begin
        bit     sat;
        longint v;
        int     n, mode, sh, k;
        bit     relu;

        ap_rst  = 1'b1;
        out_rdy = 1'b1;
        idle_garbage();
        repeat (2) @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        mon_en = 1'b1;

        check("rst_out_vld", longint'(out_vld), 0);
        check("rst_out_dat", longint'(out_dat), 0);
        check("rst_ovf_cnt", longint'(ovf_cnt), 0);
        check("rst_prod_rdy", longint'(prod_rdy), 1);

        // Pin the reference model with hand-worked values.
        check("model_round_pos", requant(24, 4, 1'b0, sat), 2);
        check("model_round_neg", requant(-24, 4, 1'b0, sat), -1);
        check("model_relu_sat", requant(-40000, 0, 1'b1, sat), 0);
        check("model_relu_sat_flag", longint'(sat), 1);

        beats[0] = 100; beats[1] = 200; beats[2] = 300;
        send_vec(3, 0, 1'b0, 1'b1, 0);
        expect_result("accum600", 600, 0);

        single(24, 4, 1'b0, "round24", 2, 0);
        single(-24, 4, 1'b0, "roundm24", -1, 0);
        single(23, 4, 1'b0, "round23", 1, 0);

        beats[0] = 64'h1FFFFFFF; beats[1] = 64'h1FFFFFFF;
        send_vec(2, 0, 1'b0, 1'b1, 0);
        expect_result("sat_pos", 32767, 1);
        single(-64'sd536870912, 0, 1'b0, "sat_neg", -32768, 2);

        beats[0] = -300; beats[1] = -200;
        send_vec(2, 0, 1'b1, 1'b1, 0);
        expect_result("relu_on", 0, 2);
        send_vec(2, 0, 1'b0, 1'b1, 0);
        expect_result("relu_off", -500, 2);

        // Backpressure: held result stays stable and input stays stalled.
        out_rdy = 1'b0;
        beats[0] = 5;
        send_vec(1, 0, 1'b0, 1'b1, 0);
        @(posedge ap_clk);
        #1;
        for (int c = 0; c < 6; c++) begin
            check("bp_vld", longint'(out_vld), 1);
            check("bp_dat", longint'(out_dat), 5);
            check("bp_prod_rdy", longint'(prod_rdy), 0);
            @(posedge ap_clk);
            #1;
        end
        out_rdy = 1'b1;
        @(posedge ap_clk);
        #1;
        check("bp_release_vld", longint'(out_vld), 0);
        check("bp_release_rdy", longint'(prod_rdy), 1);

        // Reset mid-vector discards the partial sum and the overflow count.
        beats[0] = 1000; beats[1] = 2000;
        send_vec(2, 0, 1'b0, 1'b0, 0);
        do_reset();
        check("midrst_ovf", longint'(ovf_cnt), 0);
        single(7, 0, 1'b0, "after_rst", 7, 0);

        // Reset while holding an unsent result.
        out_rdy = 1'b0;
        beats[0] = 9;
        send_vec(1, 0, 1'b0, 1'b1, 0);
        @(posedge ap_clk);
        #1;
        check("hold_vld_before_rst", longint'(out_vld), 1);
        do_reset();
        check("hold_rst_vld", longint'(out_vld), 0);
        check("hold_rst_prod_rdy", longint'(prod_rdy), 1);
        out_rdy = 1'b1;

        // Randomized vectors with gaps and random downstream backpressure.
        rand_rdy = 1'b1;
        for (int t = 0; t < 80; t++) begin
            n    = $urandom_range(1, 6);
            mode = $urandom_range(0, 2);
            for (int i = 0; i < n; i++) begin
                if (mode == 0) begin
                    v = longint'($urandom) & 64'h3FFFFFFF;
                    if (v >= (64'sd1 <<< 29)) v -= (64'sd1 <<< 30);
                end else if (mode == 1) begin
                    v = longint'($urandom_range(0, 8000)) - 4000;
                end else begin
                    v = longint'($urandom_range(0, 2097152)) - 1048576;
                end
                beats[i] = v;
            end
            sh   = (mode == 1) ? $urandom_range(0, 6) : $urandom_range(0, 31);
            relu = 1'($urandom);
            send_vec(n, sh, relu, 1'b1, 2);
        end
        rand_rdy = 1'b0;
        out_rdy  = 1'b1;
        k = 0;
        while ((expq.size() != 0 || out_vld) && k < 100) begin
            @(posedge ap_clk);
            #1;
            k++;
        end
        check("final_drain_queue", longint'(expq.size()), 0);
        check("final_ovf", longint'(ovf_cnt), exp_ovf);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
